pe_row_sequencer: RTL and testbench
===================================

Name: pe_row_sequencer

Overview:
- Controller that runs one PE through a complete 1-D convolution row of NUM_INPUTS pixels with a NUM_WEIGHT-tap kernel.
- Reads pixels from an external line buffer (1-cycle read latency) and holds the kernel taps in an internal register file.
- Drives the PE input, weight, enable, clear and bias-request lines, counts the PE outputs, and signals done.
- Sits between the layer controller (start/done) and a single PE instance.

Parameters:
- NUM_INPUTS, 5: pixels per row. Must match the PE's numInputs.
- NUM_WEIGHT, 3: kernel taps. Must match the PE's numWeight.
- DATA_WIDTH, 8: pixel width, unsigned.
- Derived localparams:
  - N_OUT = NUM_INPUTS-NUM_WEIGHT+1
  - ADDR_W = $clog2(NUM_INPUTS)
  - TOTAL = N_OUT*NUM_WEIGHT

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a row; sampled only in IDLE
- hold  in  1  pause read issue (upstream not ready)
- w_wr_en  in  1  weight register write strobe
- w_wr_idx  in  $clog2(NUM_WEIGHT)  tap index
- w_wr_data  in  16  signed Q2.14 tap value
- in_rd_en  out  1  line-buffer read strobe
- in_rd_addr  out  ADDR_W  line-buffer read address
- in_rd_data  in  DATA_WIDTH  read data, valid the cycle after in_rd_en
- pe_clear  out  1  PE clear pulse
- pe_enable  out  1  PE enable
- pe_input_valid  out  1  drives PE myinputValid
- pe_input  out  DATA_WIDTH  drives PE myinput (in_rd_data passthrough)
- pe_weight  out  16  drives PE weightValue
- pe_bias_req_enable  out  1  drives PE bias_req_enable
- pe_outvalid  in  1  from PE outvalid
- pe_ready_for_next  in  1  from PE pe_ready_for_next
- busy  out  1  row in progress
- done  out  1  one-cycle pulse, row complete
- err  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; all counters and the weight register file clear to 0.
  - All outputs are 0, including err.
  - Reset mid-row abandons the row; no done pulse is produced.
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE: busy=0. start=1 moves to CLEAR.
- CLEAR: one cycle, pe_clear=1, busy=1. Position counter pos=0, tap counter k=0, out_cnt=0. Next state is ISSUE.
- ISSUE, when hold=0:
  - in_rd_en=1, in_rd_addr=pos+k.
  - A registered copy of weight[k] is presented on pe_weight the next cycle.
  - k wraps at NUM_WEIGHT-1, and pos increments on that wrap.
  - The read with pos=N_OUT-1 and k=NUM_WEIGHT-1 is the last one; the next state is DRAIN.
- ISSUE, when hold=1: in_rd_en=0, and counters and weight are frozen.
- Read pipeline: pe_input_valid is in_rd_en delayed one cycle. pe_input is in_rd_data. pe_weight and pe_input_valid change together.
  - A read issued in the cycle before hold rises still completes.
- pe_enable=busy and pe_bias_req_enable=busy.
- DRAIN:
  - out_cnt increments on each pe_outvalid.
  - When out_cnt reaches N_OUT, the next state is DONE.
  - pe_ready_for_next must coincide with the N_OUT-th group. If it arrives with out_cnt != N_OUT-1 relative to the group count, set err.
- DONE: done=1 for one cycle, busy=1. Next state is IDLE, where busy=0.
- Latency, with no hold: done rises 4 cycles after the last in_rd_en cycle. Start-to-done is TOTAL+5 cycles (14 for the defaults).
- Counting: out_cnt counts pe_outvalid in every busy state, not only in DRAIN.
- err (sticky, cleared only by reset) is set when either of these occurs:
  - pe_outvalid is seen in IDLE.
  - out_cnt would exceed N_OUT.
- Weight writes: accepted only in IDLE. In any other state they are ignored and the register file is unchanged.
- start while busy is ignored.
- start and w_wr_en in the same IDLE cycle: the write lands and the row uses the new value.

Decomposition:
- Package pe_seq_pkg holds:
  - the state enum;
  - the Q2.14 weight width (16);
  - the accumulator width (32).
- Sub-module pe_weight_regfile: NUM_WEIGHT x 16-bit, synchronous write, registered read, indexed by k.
- The FSM, counters and pipeline delay stay in the top module.

Test Plan:
- Address order: line buffer holds [1,2,3,4,5], weights [16384,0,-16384], start pulse.
  - in_rd_addr sequence must be 0,1,2,1,2,3,2,3,4 on consecutive cycles.
  - pe_weight must repeat 16384,0,-16384, aligned with pe_input_valid.
- End-to-end with the real PE and bias 0: the same row as above.
  - PE outputs must be -8388608 three times.
  - done must be high in cycle 14 after start.
  - err must stay 0.
- Hold: hold=1 for 3 cycles after the 4th read.
  - The read sequence resumes at address 2, with no duplicates and no gaps.
  - done is delayed by exactly 3 cycles.
- Ignored inputs: start pulsed during ISSUE, and a w_wr_en of tap 0 to 100 during DRAIN.
  - There must be no restart and no change to the outputs.
  - The next row must still use weight 16384.
- Reset mid-row: rst_n low for 1 cycle while in ISSUE.
  - All outputs go to 0 immediately, asynchronously.
  - No done pulse; state IDLE.
  - The next start runs a full correct row.
- Protocol errors:
  - Force pe_outvalid=1 in IDLE: err becomes 1 and stays 1 until rst_n.
  - Inject one extra outvalid during a row: err is set.

Source files
------------

// File: rtl/pe_seq_pkg.sv
// Shared types and widths for the PE row sequencer.
package pe_seq_pkg;

  // Q2.14 kernel tap width.
  localparam int unsigned WeightWidth = 16;
  // PE accumulator width.
  localparam int unsigned AccWidth = 32;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StIssue,
    StDrain,
    StDone
  } seq_state_e;

endpackage

// File: rtl/pe_row_sequencer_if.sv
// Bundle of the sequencer's control, line-buffer, weight-load and PE-side signals.
interface pe_row_sequencer_if
  import pe_seq_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned NUM_WEIGHT = 3,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned ADDR_W = $clog2(NUM_INPUTS);
  localparam int unsigned IDX_W  = $clog2(NUM_WEIGHT);

  logic                   start;
  logic                   hold;
  logic                   w_wr_en;
  logic [IDX_W-1:0]       w_wr_idx;
  logic [WeightWidth-1:0] w_wr_data;
  logic                   in_rd_en;
  logic [ADDR_W-1:0]      in_rd_addr;
  logic [DATA_WIDTH-1:0]  in_rd_data;
  logic                   pe_clear;
  logic                   pe_enable;
  logic                   pe_input_valid;
  logic [DATA_WIDTH-1:0]  pe_input;
  logic [WeightWidth-1:0] pe_weight;
  logic                   pe_bias_req_enable;
  logic                   pe_outvalid;
  logic                   pe_ready_for_next;
  logic                   busy;
  logic                   done;
  logic                   err;

  // Sequencer side.
  modport master (
    input  start, hold, w_wr_en, w_wr_idx, w_wr_data, in_rd_data,
           pe_outvalid, pe_ready_for_next,
    output in_rd_en, in_rd_addr, pe_clear, pe_enable, pe_input_valid, pe_input,
           pe_weight, pe_bias_req_enable, busy, done, err
  );

  // Environment side: layer controller, line buffer and PE.
  modport slave (
    output start, hold, w_wr_en, w_wr_idx, w_wr_data, in_rd_data,
           pe_outvalid, pe_ready_for_next,
    input  in_rd_en, in_rd_addr, pe_clear, pe_enable, pe_input_valid, pe_input,
           pe_weight, pe_bias_req_enable, busy, done, err
  );

endinterface

// File: rtl/pe_weight_regfile.sv
// Kernel tap register file: synchronous write, registered read that holds when not enabled.
module pe_weight_regfile
  import pe_seq_pkg::*;
#(
  parameter int unsigned NUM_WEIGHT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_WEIGHT)-1:0] wr_idx,
  input  logic [WeightWidth-1:0]        wr_data,
  input  logic                          rd_en,
  input  logic [$clog2(NUM_WEIGHT)-1:0] rd_idx,
  output logic [WeightWidth-1:0]        rd_data
);

  logic [WeightWidth-1:0] mem_q [NUM_WEIGHT];
  logic [WeightWidth-1:0] rd_data_q;

  // Tap storage and read register; both clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_WEIGHT; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_idx] <= wr_data;
      end
      if (rd_en) begin
        rd_data_q <= mem_q[rd_idx];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pe_row_sequencer.sv
// Walks one PE through a 1-D convolution row: issues line-buffer reads in
// sliding-window order, pairs each pixel with its tap, counts PE results.
module pe_row_sequencer
  import pe_seq_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned NUM_WEIGHT = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  pe_row_sequencer_if.master  bus
);

  localparam int unsigned N_OUT  = NUM_INPUTS - NUM_WEIGHT + 1;
  localparam int unsigned ADDR_W = $clog2(NUM_INPUTS);
  localparam int unsigned IDX_W  = $clog2(NUM_WEIGHT);
  localparam int unsigned CNT_W  = $clog2(N_OUT + 1);

  localparam logic [IDX_W-1:0]  KLast   = IDX_W'(NUM_WEIGHT - 1);
  localparam logic [ADDR_W-1:0] PosLast = ADDR_W'(N_OUT - 1);
  localparam logic [CNT_W-1:0]  CntFull = CNT_W'(N_OUT);
  localparam logic [CNT_W-1:0]  CntLast = CNT_W'(N_OUT - 1);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] pos_q;
  logic [IDX_W-1:0]  k_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic              err_q;
  logic              in_valid_q;
  logic              busy;
  logic              rd_en;

  assign busy  = (state_q != StIdle);
  assign rd_en = (state_q == StIssue) && !bus.hold;

  // Control FSM with position/tap/output counters, sticky error and read-valid delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pos_q      <= '0;
      k_q        <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      in_valid_q <= rd_en;

      if (!busy && bus.pe_outvalid) begin
        err_q <= 1'b1;
      end
      if (busy && bus.pe_outvalid) begin
        if (out_cnt_q == CntFull) begin
          err_q <= 1'b1;
        end else begin
          out_cnt_q <= out_cnt_q + 1'b1;
        end
      end
      // The PE flags the last group; it must line up with our own count.
      if (busy && bus.pe_ready_for_next && (out_cnt_q != CntLast)) begin
        err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StClear;
          end
        end
        StClear: begin
          pos_q     <= '0;
          k_q       <= '0;
          out_cnt_q <= '0;
          state_q   <= StIssue;
        end
        StIssue: begin
          if (!bus.hold) begin
            if (k_q == KLast) begin
              k_q <= '0;
              if (pos_q == PosLast) begin
                state_q <= StDrain;
              end else begin
                pos_q <= pos_q + 1'b1;
              end
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (out_cnt_q == CntFull) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Taps load only while idle so a running row sees a stable kernel.
  pe_weight_regfile #(
    .NUM_WEIGHT(NUM_WEIGHT)
  ) u_weight_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (bus.w_wr_en && (state_q == StIdle)),
    .wr_idx (bus.w_wr_idx),
    .wr_data(bus.w_wr_data),
    .rd_en  (rd_en),
    .rd_idx (k_q),
    .rd_data(bus.pe_weight)
  );

  assign bus.in_rd_en           = rd_en;
  assign bus.in_rd_addr         = pos_q + ADDR_W'(k_q);
  assign bus.pe_clear           = (state_q == StClear);
  assign bus.pe_enable          = busy;
  assign bus.pe_bias_req_enable = busy;
  assign bus.busy               = busy;
  assign bus.done               = (state_q == StDone);
  assign bus.err                = err_q;
  assign bus.pe_input_valid     = in_valid_q;
  // Pixel passes straight through; zeroed outside valid cycles so reset drives all-zero.
  assign bus.pe_input = in_valid_q ? bus.in_rd_data : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Directed bench for pe_row_sequencer with a line-buffer model and a reference PE model.
module tb_pe_row_sequencer;
  import pe_seq_pkg::*;

  localparam int NI    = 5;
  localparam int NW    = 3;
  localparam int DW    = 8;
  localparam int N_OUT = NI - NW + 1;
  localparam int TOTAL = N_OUT * NW;
  localparam int ROW_RESULT = -8388608;

  logic clk = 1'b0;
  logic rst_n;
  logic inj;

  always #5 clk = ~clk;

  pe_row_sequencer_if #(.NUM_INPUTS(NI), .NUM_WEIGHT(NW), .DATA_WIDTH(DW)) bus ();

  pe_row_sequencer #(
    .NUM_INPUTS(NI),
    .NUM_WEIGHT(NW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Line buffer holding pixels 1..5, one-cycle read latency.
  logic [DW-1:0] lb [NI] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
  logic [DW-1:0] lb_q;
  always @(posedge clk) begin
    if (bus.in_rd_en) lb_q <= lb[bus.in_rd_addr];
  end
  assign bus.in_rd_data = lb_q;

  // Reference PE: pixel taken as 8.8 fixed point, times Q2.14 tap, accumulated per window.
  logic signed [AccWidth-1:0] m_acc, m_sum, m_res;
  int   m_tap, m_grp;
  logic m_ov, m_rdy;
  always_comb begin
    m_sum = m_acc + $signed({16'd0, bus.pe_input, 8'd0}) *
                    $signed({{16{bus.pe_weight[15]}}, bus.pe_weight});
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= '0; m_tap <= 0; m_grp <= 0; m_ov <= 1'b0; m_rdy <= 1'b0; m_res <= '0;
    end else begin
      m_ov  <= 1'b0;
      m_rdy <= 1'b0;
      if (bus.pe_clear) begin
        m_acc <= '0; m_tap <= 0; m_grp <= 0;
      end else if (bus.pe_input_valid) begin
        if (m_tap == NW - 1) begin
          m_ov  <= 1'b1;
          m_res <= m_sum;
          m_rdy <= (m_grp == N_OUT - 1);
          m_acc <= '0;
          m_tap <= 0;
          m_grp <= m_grp + 1;
        end else begin
          m_acc <= m_sum;
          m_tap <= m_tap + 1;
        end
      end
    end
  end
  assign bus.pe_outvalid       = m_ov | inj;
  assign bus.pe_ready_for_next = m_rdy;

  int n_chk  = 0;
  int n_pass = 0;

  int exp_addr [9] = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
  int exp_w    [3] = '{16384, 0, -16384};

  int addr_q[$];
  int w_q[$];
  int in_q[$];
  int out_q[$];
  int rd_first, rd_last, done_cyc, done_cnt, clear_cyc, clear_cnt;

  task automatic write_w(input int idx, input int val);
    bus.w_wr_en   = 1'b1;
    bus.w_wr_idx  = 2'(idx);
    bus.w_wr_data = 16'(val);
    @(negedge clk);
    bus.w_wr_en   = 1'b0;
  endtask

  task automatic load_weights();
    write_w(0, 16384);
    write_w(1, 0);
    write_w(2, -16384);
  endtask

  // Starts a row (start high in cycle 0) and records 40 cycles of activity.
  task automatic run_row(input int hold_after, input int hold_len, input int inj_cyc,
                         input int restart_cyc, input int wr_cyc);
    int  nreads;
    int  hold_left;
    bit  hold_done;
    addr_q = {}; w_q = {}; in_q = {}; out_q = {};
    rd_first = -1; rd_last = -1; done_cyc = -1; done_cnt = 0; clear_cyc = -1; clear_cnt = 0;
    nreads = 0; hold_left = 0; hold_done = 1'b0;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus.in_rd_en) begin
        addr_q.push_back(int'(bus.in_rd_addr));
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
        nreads++;
      end
      if (bus.pe_input_valid) begin
        w_q.push_back(int'($signed(bus.pe_weight)));
        in_q.push_back(int'(bus.pe_input));
      end
      if (m_ov) out_q.push_back(int'(m_res));
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.pe_clear) begin clear_cnt++; if (clear_cyc < 0) clear_cyc = cyc; end
      bus.start     = (cyc == restart_cyc);
      inj           = (cyc == inj_cyc);
      bus.w_wr_en   = (cyc == wr_cyc);
      bus.w_wr_idx  = '0;
      bus.w_wr_data = 16'd100;
      if (hold_left > 0) begin
        bus.hold = 1'b1;
        hold_left--;
      end else if (!hold_done && hold_after > 0 && nreads == hold_after) begin
        bus.hold  = 1'b1;
        hold_left = hold_len - 1;
        hold_done = 1'b1;
      end else begin
        bus.hold = 1'b0;
      end
    end
    bus.start = 1'b0; inj = 1'b0; bus.w_wr_en = 1'b0; bus.hold = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    #1;
    flags = {bus.busy, bus.done, bus.err, bus.in_rd_en, bus.pe_clear, bus.pe_enable,
             bus.pe_input_valid, bus.pe_bias_req_enable};
    n_chk++;
    if (flags !== 8'h00) $display("FAIL reset_flags: got %b want 00000000", flags);
    else n_pass++;
    n_chk++;
    if (bus.pe_weight !== 16'd0) $display("FAIL reset_weight: got %0d want 0", bus.pe_weight);
    else n_pass++;
    n_chk++;
    if (bus.in_rd_addr !== 3'd0) $display("FAIL reset_addr: got %0d want 0", bus.in_rd_addr);
    else n_pass++;
    @(negedge clk);
    do_reset();
    n_chk++;
    if ({bus.busy, bus.err} !== 2'b00) $display("FAIL idle_after_reset: got %b want 00",
                                                {bus.busy, bus.err});
    else n_pass++;
  endtask

  task automatic test_address_order();
    load_weights();
    run_row(0, 0, 0, 0, 0);
    n_chk++;
    if (clear_cyc !== 1 || clear_cnt !== 1)
      $display("FAIL clear_pulse: got cyc %0d cnt %0d want cyc 1 cnt 1", clear_cyc, clear_cnt);
    else n_pass++;
    n_chk++;
    if (addr_q.size() !== 9) $display("FAIL read_count: got %0d want 9", addr_q.size());
    else n_pass++;
    for (int i = 0; i < addr_q.size() && i < 9; i++) begin
      n_chk++;
      if (addr_q[i] !== exp_addr[i])
        $display("FAIL addr[%0d]: got %0d want %0d", i, addr_q[i], exp_addr[i]);
      else n_pass++;
    end
    n_chk++;
    if (rd_first !== 2 || rd_last !== 10)
      $display("FAIL read_window: got %0d..%0d want 2..10", rd_first, rd_last);
    else n_pass++;
    n_chk++;
    if (w_q.size() !== 9) $display("FAIL weight_count: got %0d want 9", w_q.size());
    else n_pass++;
    for (int i = 0; i < w_q.size() && i < 9; i++) begin
      n_chk++;
      if (w_q[i] !== exp_w[i % 3] || in_q[i] !== exp_addr[i] + 1)
        $display("FAIL pair[%0d]: got w %0d px %0d want w %0d px %0d", i, w_q[i], in_q[i],
                 exp_w[i % 3], exp_addr[i] + 1);
      else n_pass++;
    end
    n_chk++;
    if (done_cyc !== TOTAL + 5 || done_cnt !== 1)
      $display("FAIL done_cycle: got %0d (x%0d) want %0d (x1)", done_cyc, done_cnt, TOTAL + 5);
    else n_pass++;
    n_chk++;
    if (out_q.size() !== N_OUT) $display("FAIL out_count: got %0d want %0d", out_q.size(), N_OUT);
    else n_pass++;
    for (int i = 0; i < out_q.size(); i++) begin
      n_chk++;
      if (out_q[i] !== ROW_RESULT)
        $display("FAIL pe_out[%0d]: got %0d want %0d", i, out_q[i], ROW_RESULT);
      else n_pass++;
    end
    n_chk++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL row_end: got err %b busy %b want 0 0", bus.err, bus.busy);
    else n_pass++;
  endtask

  task automatic test_hold();
    run_row(4, 3, 0, 0, 0);
    n_chk++;
    if (addr_q.size() !== 9) $display("FAIL hold_read_count: got %0d want 9", addr_q.size());
    else n_pass++;
    for (int i = 0; i < addr_q.size() && i < 9; i++) begin
      n_chk++;
      if (addr_q[i] !== exp_addr[i])
        $display("FAIL hold_addr[%0d]: got %0d want %0d", i, addr_q[i], exp_addr[i]);
      else n_pass++;
    end
    n_chk++;
    if (rd_last !== 13) $display("FAIL hold_last_read: got %0d want 13", rd_last);
    else n_pass++;
    n_chk++;
    if (done_cyc !== TOTAL + 8) $display("FAIL hold_done: got %0d want %0d", done_cyc, TOTAL + 8);
    else n_pass++;
    n_chk++;
    if (out_q.size() !== N_OUT || out_q[N_OUT-1] !== ROW_RESULT || bus.err !== 1'b0)
      $display("FAIL hold_result: got n %0d err %b want n %0d err 0", out_q.size(), bus.err, N_OUT);
    else n_pass++;
  endtask

  task automatic test_ignored_inputs();
    run_row(0, 0, 0, 5, 12);
    n_chk++;
    if (clear_cnt !== 1 || done_cnt !== 1 || done_cyc !== TOTAL + 5)
      $display("FAIL no_restart: got clears %0d dones %0d at %0d want 1 1 at %0d",
               clear_cnt, done_cnt, done_cyc, TOTAL + 5);
    else n_pass++;
    n_chk++;
    if (addr_q.size() !== 9 || addr_q[8] !== 4)
      $display("FAIL ignored_reads: got n %0d want 9 ending at 4", addr_q.size());
    else n_pass++;
    run_row(0, 0, 0, 0, 0);
    n_chk++;
    if (w_q.size() < 1 || w_q[0] !== 16384)
      $display("FAIL tap0_kept: got %0d want 16384", (w_q.size() > 0) ? w_q[0] : -1);
    else n_pass++;
    n_chk++;
    if (out_q.size() !== N_OUT || out_q[0] !== ROW_RESULT)
      $display("FAIL next_row: got n %0d want %0d results of %0d", out_q.size(), N_OUT,
               ROW_RESULT);
    else n_pass++;
  endtask

  task automatic test_reset_mid_row();
    logic [7:0] flags;
    int dones;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({bus.busy, bus.in_rd_en, bus.pe_enable} !== 3'b111)
      $display("FAIL mid_row_active: got %b want 111", {bus.busy, bus.in_rd_en, bus.pe_enable});
    else n_pass++;
    rst_n = 1'b0;
    #1;
    flags = {bus.busy, bus.done, bus.err, bus.in_rd_en, bus.pe_clear, bus.pe_enable,
             bus.pe_input_valid, bus.pe_bias_req_enable};
    n_chk++;
    if (flags !== 8'h00 || bus.pe_weight !== 16'd0 || bus.in_rd_addr !== 3'd0 ||
        bus.pe_input !== 8'd0)
      $display("FAIL async_reset: got flags %b w %0d addr %0d px %0d want all 0", flags,
               bus.pe_weight, bus.in_rd_addr, bus.pe_input);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_chk++;
    if (dones !== 0 || bus.busy !== 1'b0)
      $display("FAIL abandoned_row: got dones %0d busy %b want 0 0", dones, bus.busy);
    else n_pass++;
    // Register file was cleared by reset.
    run_row(0, 0, 0, 0, 0);
    n_chk++;
    if (w_q.size() !== 9 || w_q[0] !== 0 || w_q[2] !== 0 || out_q.size() < 1 || out_q[0] !== 0)
      $display("FAIL cleared_taps: got n %0d w0 %0d want 9 taps of 0", w_q.size(),
               (w_q.size() > 0) ? w_q[0] : -1);
    else n_pass++;
    load_weights();
    run_row(0, 0, 0, 0, 0);
    n_chk++;
    if (addr_q.size() !== 9 || done_cyc !== TOTAL + 5 || out_q.size() !== N_OUT ||
        out_q[2] !== ROW_RESULT)
      $display("FAIL row_after_reset: got reads %0d done %0d outs %0d want 9 %0d %0d",
               addr_q.size(), done_cyc, out_q.size(), TOTAL + 5, N_OUT);
    else n_pass++;
  endtask

  task automatic test_protocol_err();
    n_chk++;
    if (bus.err !== 1'b0) $display("FAIL err_clear_before: got %b want 0", bus.err);
    else n_pass++;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    n_chk++;
    if (bus.err !== 1'b1) $display("FAIL err_idle_outvalid: got %b want 1", bus.err);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_chk++;
    if (bus.err !== 1'b1) $display("FAIL err_sticky: got %b want 1", bus.err);
    else n_pass++;
    do_reset();
    n_chk++;
    if (bus.err !== 1'b0) $display("FAIL err_reset: got %b want 0", bus.err);
    else n_pass++;
    load_weights();
    run_row(0, 0, 5, 0, 0);
    n_chk++;
    if (bus.err !== 1'b1) $display("FAIL err_extra_outvalid: got %b want 1", bus.err);
    else n_pass++;
    do_reset();
  endtask

  initial begin
    bus.start = 1'b0; bus.hold = 1'b0; bus.w_wr_en = 1'b0;
    bus.w_wr_idx = '0; bus.w_wr_data = '0;
    inj = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_address_order();
    test_hold();
    test_ignored_inputs();
    test_reset_mid_row();
    test_protocol_err();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish within 200000 want finish");
    $fatal(1, "timeout");
  end

endmodule
